// File: rtl/diferenca_seq_if.sv
// ============================================================================
//  Module      : diferenca_seq_if
//  Description : Operand/result handshake bundle for the diferenca sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface diferenca_seq_if #(
  parameter int WIDTH = 4,
  parameter int SAD_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             sinal;
  logic [SAD_W-1:0] sad;
  logic             sad_valid;
  logic             sad_sat;

  modport master (
    output in_valid, a, b, last, out_ready,
    input  in_ready, out_valid, diff, sinal, sad, sad_valid, sad_sat
  );

  modport slave (
    input  in_valid, a, b, last, out_ready,
    output in_ready, out_valid, diff, sinal, sad, sad_valid, sad_sat
  );
endinterface

`default_nettype wire

// File: rtl/diferenca_seq.sv
// ============================================================================
//  Module      : diferenca_seq (with datapath diferenca)
//  Description : Handshaked |A-B| / sign sequencer with saturating SAD.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module diferenca #(
  parameter int WIDTH = 4
) (
  input  wire logic [WIDTH-1:0] i_a,
  input  wire logic [WIDTH-1:0] i_b,
  output logic      [WIDTH-1:0] o_diff,
  output logic                  o_sinal
);
  logic w_neg;

  assign w_neg   = (i_a < i_b);
  assign o_sinal = w_neg;
  assign o_diff  = w_neg ? (i_b - i_a) : (i_a - i_b);
endmodule

module diferenca_seq #(
  parameter int WIDTH = 4,
  parameter int SAD_W = 8
) (
  input  wire logic          clk,
  input  wire logic          rst,
  diferenca_seq_if.slave     bus
);
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [SAD_W-1:0] C_SAD_MAX = {SAD_W{1'b1}};

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_last;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_diff;
  logic             r_sinal;
  logic [SAD_W-1:0] r_acc;
  logic             r_acc_sat;
  logic [SAD_W-1:0] r_sad;
  logic             r_sad_valid;
  logic             r_sad_sat;

  logic [WIDTH-1:0] w_diff;
  logic             w_sinal;
  logic [SAD_W:0]   w_sum;
  logic             w_ovf;

  diferenca #(
    .WIDTH (WIDTH)
  ) u_diferenca (
    .i_a     (r_a),
    .i_b     (r_b),
    .o_diff  (w_diff),
    .o_sinal (w_sinal)
  );

  // One extra bit catches overflow so the accumulator clamps instead of wrapping.
  assign w_sum = {1'b0, r_acc} + {{(SAD_W + 1 - WIDTH){1'b0}}, w_diff};
  assign w_ovf = w_sum[SAD_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_last      <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_diff      <= '0;
      r_sinal     <= 1'b0;
      r_acc       <= '0;
      r_acc_sat   <= 1'b0;
      r_sad       <= '0;
      r_sad_valid <= 1'b0;
      r_sad_sat   <= 1'b0;
    end else begin
      r_sad_valid <= 1'b0;
      r_sad       <= '0;
      r_sad_sat   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_a        <= bus.a;
            r_b        <= bus.b;
            r_last     <= bus.last;
            r_in_ready <= 1'b0;
            r_state    <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_diff  <= w_diff;
          r_sinal <= w_sinal;
          if (w_ovf) begin
            r_acc     <= C_SAD_MAX;
            r_acc_sat <= 1'b1;
          end else begin
            r_acc <= w_sum[SAD_W-1:0];
          end
          r_out_valid <= 1'b1;
          r_state     <= S_RESP;
        end
        S_RESP: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
            if (r_last) begin
              r_sad_valid <= 1'b1;
              r_sad       <= r_acc;
              r_sad_sat   <= r_acc_sat;
              r_acc       <= '0;
              r_acc_sat   <= 1'b0;
            end
          end
        end
        default: begin
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.diff      = r_diff;
  assign bus.sinal     = r_sinal;
  assign bus.sad       = r_sad;
  assign bus.sad_valid = r_sad_valid;
  assign bus.sad_sat   = r_sad_sat;
endmodule

`default_nettype wire

// File: tb/tb_diferenca_seq.sv
// ============================================================================
//  Module      : tb_diferenca_seq
//  Description : Randomized self-checking bench for diferenca_seq.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_diferenca_seq;
  localparam int WIDTH = 4;
  localparam int SAD_W = 8;
  localparam int SAD_MAX = (1 << SAD_W) - 1;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  int   acc_model;

  diferenca_seq_if #(.WIDTH(WIDTH), .SAD_W(SAD_W)) bus ();

  diferenca_seq #(
    .WIDTH (WIDTH),
    .SAD_W (SAD_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".in_ready"},  32'(bus.in_ready),  1);
    check({tag, ".out_valid"}, 32'(bus.out_valid), 0);
    check({tag, ".diff"},      32'(bus.diff),      0);
    check({tag, ".sinal"},     32'(bus.sinal),     0);
    check({tag, ".sad"},       32'(bus.sad),       0);
    check({tag, ".sad_valid"}, 32'(bus.sad_valid), 0);
    check({tag, ".sad_sat"},   32'(bus.sad_sat),   0);
  endtask

  // Drives one pair through the full handshake; stall = cycles of out_ready=0 in RESP.
  task automatic send_pair(input int av, input int bv, input bit lst,
                           input int stall, input bit junk);
    int exp_diff;
    int exp_sinal;
    int exp_sad;
    int exp_sat;
    exp_diff  = (av >= bv) ? av - bv : bv - av;
    exp_sinal = (av < bv) ? 1 : 0;
    acc_model += exp_diff;

    check("idle.in_ready", 32'(bus.in_ready), 1);
    bus.in_valid = 1'b1;
    bus.a        = WIDTH'(av);
    bus.b        = WIDTH'(bv);
    bus.last     = lst;
    tick();
    bus.in_valid = 1'b0;
    bus.a        = WIDTH'($urandom);
    bus.b        = WIDTH'($urandom);
    check("exec.out_valid", 32'(bus.out_valid), 0);
    check("exec.in_ready",  32'(bus.in_ready),  0);
    tick();
    check("resp.out_valid", 32'(bus.out_valid), 1);
    check("resp.diff",      32'(bus.diff),      32'(exp_diff));
    check("resp.sinal",     32'(bus.sinal),     32'(exp_sinal));
    for (int k = 0; k < stall; k++) begin
      if (junk) bus.in_valid = (k % 2 == 0);
      tick();
      check("stall.out_valid", 32'(bus.out_valid), 1);
      check("stall.in_ready",  32'(bus.in_ready),  0);
      check("stall.diff",      32'(bus.diff),      32'(exp_diff));
      check("stall.sinal",     32'(bus.sinal),     32'(exp_sinal));
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("done.out_valid", 32'(bus.out_valid), 0);
    check("done.in_ready",  32'(bus.in_ready),  1);
    if (lst) begin
      exp_sad   = (acc_model > SAD_MAX) ? SAD_MAX : acc_model;
      exp_sat   = (acc_model > SAD_MAX) ? 1 : 0;
      acc_model = 0;
      check("end.sad_valid", 32'(bus.sad_valid), 1);
      check("end.sad",       32'(bus.sad),       32'(exp_sad));
      check("end.sad_sat",   32'(bus.sad_sat),   32'(exp_sat));
    end else begin
      check("mid.sad_valid", 32'(bus.sad_valid), 0);
      check("mid.sad",       32'(bus.sad),       0);
    end
    tick();
    check("post.sad_valid", 32'(bus.sad_valid), 0);
    check("post.sad",       32'(bus.sad),       0);
    check("post.sad_sat",   32'(bus.sad_sat),   0);
  endtask

  initial begin
    int len;
    n_checks      = 0;
    n_errors      = 0;
    acc_model     = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.last      = 1'b0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();

    send_pair(9, 3, 1'b1, 0, 1'b0);
    send_pair(0, 15, 1'b0, 1, 1'b0);
    send_pair(7, 7, 1'b1, 0, 1'b0);
    send_pair(5, 2, 1'b0, 0, 1'b0);
    send_pair(1, 4, 1'b0, 2, 1'b0);
    send_pair(8, 8, 1'b0, 0, 1'b0);
    send_pair(0, 9, 1'b1, 1, 1'b0);

    for (int i = 0; i < 18; i++) send_pair(15, 0, (i == 17), 0, 1'b0);
    send_pair(2, 6, 1'b1, 0, 1'b0);

    send_pair(3, 11, 1'b1, 5, 1'b1);

    // Reset while the second pair of a sequence sits in EXEC.
    send_pair(12, 1, 1'b0, 0, 1'b0);
    bus.in_valid = 1'b1;
    bus.a        = 4'd10;
    bus.b        = 4'd0;
    bus.last     = 1'b0;
    tick();
    bus.in_valid = 1'b0;
    rst          = 1'b1;
    tick();
    rst       = 1'b0;
    acc_model = 0;
    check_reset_outputs("midrst");
    send_pair(4, 1, 1'b1, 0, 1'b0);

    for (int s = 0; s < 25; s++) begin
      len = int'($urandom_range(1, 6));
      for (int p = 0; p < len; p++)
        send_pair(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                  (p == len - 1), int'($urandom_range(0, 3)), 1'($urandom));
    end
    for (int i = 0; i < 20; i++)
      send_pair(int'($urandom_range(10, 15)), int'($urandom_range(0, 3)),
                (i == 19), 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=1 expected=0");
    $fatal(1);
  end
endmodule

`default_nettype wire
